// File: rtl/vec3_sched_pkg.sv
// Shared types for the normalizer scheduler: Q8.8 fixed-point vec3 and the tag that
// travels alongside each vector through the normalizer.
package vec3_sched_pkg;

    localparam int unsigned ISSUE_LATENCY = 1;
    localparam int unsigned FIX_W         = 16;
    localparam int unsigned VEC3_W        = 3 * FIX_W;
    // Wide enough for the largest supported requester count (8).
    localparam int unsigned TAG_ID_W      = 3;

    typedef logic signed [FIX_W-1:0] fixed_t;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
    } vec3_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                zero;
    } norm_tag_t;

    function automatic logic is_zero(vec3_t v);
        return (v.x == '0) && (v.y == '0) && (v.z == '0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after 'last'.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gr
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] idx;

    always_comb begin
        gr  = '0;
        idx = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IW'((32'(last) + k) % N);
            if (req[idx] && (gr == '0)) begin
                gr[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec3_normalize.sv
// Pipelined Q8.8 vec3 normalizer, six register stages, no reset on the datapath.
// Stages: sum of squares, square root, divide, then three balancing stages.
module vec3_normalize
    import vec3_sched_pkg::*;
(
    input  logic              clk_in,
    input  logic [VEC3_W-1:0] in_vec,
    output logic [VEC3_W-1:0] out_vec
);

    localparam int unsigned LATENCY = 6;
    localparam int unsigned DLY     = LATENCY - 3;

    vec3_t       v1_q, v2_q, quot_q;
    vec3_t       dly_q [DLY];
    logic [31:0] mag2_q;
    logic [23:0] mag_q;

    function automatic logic [31:0] sum_sq(vec3_t v);
        logic signed [31:0] sx, sy, sz;
        sx = v.x * v.x;
        sy = v.y * v.y;
        sz = v.z * v.z;
        return $unsigned(sx) + $unsigned(sy) + $unsigned(sz);
    endfunction

    // Restoring bit-serial square root, unrolled.
    function automatic logic [23:0] isqrt(logic [47:0] a);
        logic [27:0] rem;
        logic [27:0] trial;
        logic [23:0] root;
        rem  = '0;
        root = '0;
        for (int k = 23; k >= 0; k--) begin
            rem   = {rem[25:0], a[2*k+1 -: 2]};
            trial = {2'b00, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[22:0], 1'b1};
            end else begin
                root = {root[22:0], 1'b0};
            end
        end
        return root;
    endfunction

    // The magnitude carries 8 extra fraction bits, so the numerator is pre-shifted by 16.
    function automatic fixed_t div_comp(fixed_t c, logic [23:0] m);
        logic signed [31:0] num, den, q;
        num = {c, 16'h0000};
        den = (m == '0) ? 32'sd1 : $signed({8'h00, m});
        q   = num / den;
        return fixed_t'(q);
    endfunction

    always_ff @(posedge clk_in) begin
        v1_q     <= vec3_t'(in_vec);
        mag2_q   <= sum_sq(vec3_t'(in_vec));
        v2_q     <= v1_q;
        mag_q    <= isqrt({mag2_q, 16'h0000});
        quot_q   <= '{x: div_comp(v2_q.x, mag_q), y: div_comp(v2_q.y, mag_q),
                      z: div_comp(v2_q.z, mag_q)};
        dly_q[0] <= quot_q;
        for (int k = 1; k < DLY; k++) begin
            dly_q[k] <= dly_q[k-1];
        end
    end

    assign out_vec = dly_q[DLY-1];

endmodule

// File: rtl/vec3_normalize_arbiter.sv
// Shares one pipelined vec3 normalizer between N_REQ requesters using round-robin
// grants, a lockstep tag pipeline for result routing and per-requester credits.
module vec3_normalize_arbiter
    import vec3_sched_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned NORM_LATENCY = 6,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic [N_REQ-1:0]                          req_valid,
    input  logic [N_REQ*VEC3_W-1:0]                   req_vec,
    output logic [N_REQ-1:0]                          req_ready,
    output logic [N_REQ-1:0]                          resp_valid,
    output logic [VEC3_W-1:0]                         resp_vec,
    output logic                                      resp_zero,
    output logic [$clog2(N_REQ*MAX_INFLIGHT+1)-1:0]   inflight,
    output logic                                      busy
);

    localparam int unsigned ID_W      = $clog2(N_REQ);
    localparam int unsigned CR_W      = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned CNT_W     = $clog2(N_REQ * MAX_INFLIGHT + 1);
    localparam int unsigned TAG_DEPTH = ISSUE_LATENCY + NORM_LATENCY;

    logic [N_REQ-1:0]  eligible, grant;
    logic [ID_W-1:0]   last_q, last_d;
    logic [CR_W-1:0]   credit_q [N_REQ];
    logic [CR_W-1:0]   credit_d [N_REQ];
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    norm_tag_t         tag_q [TAG_DEPTH];
    norm_tag_t         issue_tag, resp_tag;
    vec3_t             grant_vec, issue_vec_q;
    logic [VEC3_W-1:0] norm_out;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (credit_q[i] < CR_W'(MAX_INFLIGHT));
        end
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req  (eligible),
        .last (last_q),
        .gr   (grant)
    );

    assign req_ready = grant;

    // A grant implies req_valid, so every grant is a handshake.
    always_comb begin
        last_d    = last_q;
        grant_vec = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                last_d    = ID_W'(i);
                grant_vec = vec3_t'(req_vec[i*VEC3_W +: VEC3_W]);
            end
        end
        issue_tag.valid = |grant;
        issue_tag.id    = TAG_ID_W'(last_d);
        issue_tag.zero  = is_zero(grant_vec);
    end

    always_ff @(posedge clk_in) begin
        issue_vec_q <= grant_vec;
    end

    vec3_normalize u_norm (
        .clk_in  (clk_in),
        .in_vec  (issue_vec_q),
        .out_vec (norm_out)
    );

    assign resp_tag  = tag_q[TAG_DEPTH-1];
    assign resp_zero = resp_tag.valid && resp_tag.zero;
    assign resp_vec  = (resp_tag.valid && !resp_tag.zero) ? norm_out : '0;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            resp_valid[i] = resp_tag.valid && (resp_tag.id == TAG_ID_W'(i));
        end
    end

    always_comb begin
        inflight_d = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            credit_d[i] = credit_q[i];
            if (grant[i] && !resp_valid[i]) begin
                credit_d[i] = credit_q[i] + CR_W'(1);
            end else if (!grant[i] && resp_valid[i]) begin
                credit_d[i] = credit_q[i] - CR_W'(1);
            end
            inflight_d = inflight_d + CNT_W'(credit_d[i]);
        end
    end

    // Last grant resets to the top index so requester 0 has priority first.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_q     <= ID_W'(N_REQ - 1);
            credit_q   <= '{default: '0};
            inflight_q <= '0;
            tag_q      <= '{default: '0};
        end else begin
            last_q     <= last_d;
            credit_q   <= credit_d;
            inflight_q <= inflight_d;
            tag_q[0]   <= issue_tag;
            for (int k = 1; k < TAG_DEPTH; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign inflight = inflight_q;
    assign busy     = (inflight_q != '0);

    for (genvar g = 0; g < N_REQ; g++) begin : g_credit_chk
        assert property (@(posedge clk_in) disable iff (rst_in)
                         credit_q[g] <= CR_W'(MAX_INFLIGHT));
        assert property (@(posedge clk_in) disable iff (rst_in)
                         !(resp_valid[g] && (credit_q[g] == '0)));
    end

endmodule

// File: tb/tb_vec3_normalize_arbiter.sv
// Bench for vec3_normalize_arbiter: directed phases plus random traffic, checked every
// cycle against a transaction-level model (pending-result queue, credits, round robin).
module tb_vec3_normalize_arbiter;

    localparam int N_REQ        = 4;
    localparam int MAX_INFLIGHT = 2;
    localparam int LAT          = 7;
    localparam int VW           = 48;
    localparam int CW           = $clog2(N_REQ * MAX_INFLIGHT + 1);

    logic                  clk_in    = 1'b0;
    logic                  rst_in    = 1'b1;
    logic [N_REQ-1:0]      req_valid = '0;
    logic [N_REQ*VW-1:0]   req_vec   = '0;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      resp_valid;
    logic [VW-1:0]         resp_vec;
    logic                  resp_zero;
    logic [CW-1:0]         inflight;
    logic                  busy;

    typedef struct {
        int due;
        int id;
        bit zero;
        int x;
        int y;
        int z;
    } pend_t;

    pend_t pend[$];
    int    credit_m [N_REQ];
    int    last_m;
    int    cyc;
    int    errors = 0;
    int    checks = 0;

    vec3_normalize_arbiter #(
        .N_REQ        (N_REQ),
        .NORM_LATENCY (6),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .req_valid  (req_valid),
        .req_vec    (req_vec),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_vec   (resp_vec),
        .resp_zero  (resp_zero),
        .inflight   (inflight),
        .busy       (busy)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic real absr(real a);
        return (a < 0.0) ? -a : a;
    endfunction

    task automatic chk_vec(string tag, int ex, int ey, int ez);
        real mag, qx, qy, qz;
        int  rx, ry, rz;
        bit  ok;
        mag = $sqrt(real'(ex * ex + ey * ey + ez * ez));
        qx  = real'(ex) * 256.0 / mag;
        qy  = real'(ey) * 256.0 / mag;
        qz  = real'(ez) * 256.0 / mag;
        rx  = int'($signed(resp_vec[47:32]));
        ry  = int'($signed(resp_vec[31:16]));
        rz  = int'($signed(resp_vec[15:0]));
        ok  = absr(real'(rx) - qx) <= 2.0 && absr(real'(ry) - qy) <= 2.0 &&
              absr(real'(rz) - qz) <= 2.0;
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed (%0d,%0d,%0d) expected (%f,%f,%f) +-2",
                   tag, cyc, rx, ry, rz, qx, qy, qz);
        end
    endtask

    task automatic set_vec(int i, int x, int y, int z);
        req_vec[i*VW +: VW] = {16'(x), 16'(y), 16'(z)};
    endtask

    task automatic rand_vecs();
        for (int i = 0; i < N_REQ; i++) begin
            if ($urandom_range(0, 7) == 0) set_vec(i, 0, 0, 0);
            else set_vec(i, int'($urandom_range(0, 4000)) - 2000,
                         int'($urandom_range(0, 4000)) - 2000,
                         int'($urandom_range(0, 4000)) - 2000);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < N_REQ; i++) credit_m[i] = 0;
        last_m = N_REQ - 1;
    endtask

    // One clock cycle: compare at the negedge, then advance the model past the posedge.
    task automatic cycle();
        int    win;
        int    sum;
        bit    has_resp;
        pend_t p;
        pend_t head;
        @(negedge clk_in);
        win = -1;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (last_m + k) % N_REQ;
            if (win < 0 && req_valid[idx] && credit_m[idx] < MAX_INFLIGHT) win = idx;
        end
        chk("req_ready", 64'(req_ready), (win >= 0) ? (64'd1 << win) : 64'd0);
        has_resp = (pend.size() > 0) && (pend[0].due == cyc);
        if (has_resp) begin
            head = pend.pop_front();
            chk("resp_valid", 64'(resp_valid), 64'd1 << head.id);
            chk("resp_zero", 64'(resp_zero), 64'(head.zero));
            if (head.zero) chk("resp_vec_zero", 64'(resp_vec), 64'd0);
            else chk_vec("resp_vec", head.x, head.y, head.z);
            credit_m[head.id]--;
        end else begin
            chk("resp_valid_idle", 64'(resp_valid), 64'd0);
            chk("resp_zero_idle", 64'(resp_zero), 64'd0);
        end
        sum = 0;
        for (int i = 0; i < N_REQ; i++) sum += credit_m[i] + ((has_resp && head.id == i) ? 1 : 0);
        chk("inflight", 64'(inflight), 64'(sum));
        chk("busy", 64'(busy), 64'(sum != 0));
        if (win >= 0) begin
            p.due  = cyc + LAT;
            p.id   = win;
            p.x    = int'($signed(req_vec[win*VW+32 +: 16]));
            p.y    = int'($signed(req_vec[win*VW+16 +: 16]));
            p.z    = int'($signed(req_vec[win*VW +: 16]));
            p.zero = (p.x == 0 && p.y == 0 && p.z == 0);
            pend.push_back(p);
            credit_m[win]++;
            last_m = win;
        end
        cyc++;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        model_reset();
        cyc = 0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_zero", 64'(resp_zero), 64'd0);
        chk("rst_resp_vec", 64'(resp_vec), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        rst_in = 1'b0;

        // Single request (3.0, 0, 4.0) in Q8.8.
        set_vec(0, 768, 0, 1024);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        repeat (9) cycle();

        // Zero vector is flagged and bypassed.
        set_vec(1, 0, 0, 0);
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        repeat (9) cycle();

        // All requesters contend; vectors change every cycle.
        req_valid = 4'b1111;
        repeat (24) begin
            rand_vecs();
            cycle();
        end
        req_valid = '0;
        repeat (10) cycle();

        // Requester 2 alone runs into its credit limit.
        set_vec(2, 100, -200, 300);
        req_valid = 4'b0100;
        repeat (20) cycle();
        // Requester 0 alone: re-grant coincides with a returning result.
        set_vec(0, -5, 7, 1);
        req_valid = 4'b0001;
        repeat (20) cycle();
        req_valid = '0;
        repeat (10) cycle();

        // Random traffic.
        repeat (200) begin
            req_valid = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
            rand_vecs();
            cycle();
        end
        req_valid = '0;
        repeat (10) cycle();

        // Reset mid-flight.
        rand_vecs();
        req_valid = 4'b0111;
        repeat (3) cycle();
        req_valid = '0;
        repeat (3) cycle();
        #2 rst_in = 1'b1;
        #1;
        chk("midrst_inflight", 64'(inflight), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        model_reset();
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        rand_vecs();
        req_valid = 4'b1100;
        cycle();
        req_valid = '0;
        repeat (10) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
